// File: rtl/signed_value_entry.sv
// signed_value_entry: keyed sign + two hex digits -> range-checked 8-bit two's complement value
// Ports:
//   Clock  - system clock, rising edge
//   Reset  - asynchronous active-high reset
//   Digit  - hex digit switches, sampled on a debounced Enter press
//   Neg    - sign switch (1 = negative), sampled on the first press
//   Enter  - raw push-button level, asynchronous to Clock
//   Value  - last accepted two's complement result
//   Valid  - one-cycle pulse when Value is updated
//   Error  - sticky out-of-range flag, cleared by the next good conversion
//   Stage  - current entry step (00 sign, 01 high digit, 10 low digit, 11 convert)
module signed_value_entry #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Digit,
  input  logic       Neg,
  input  logic       Enter,
  output logic [7:0] Value,
  output logic       Valid,
  output logic       Error,
  output logic [1:0] Stage
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  typedef enum logic [1:0] {S_SIGN = 2'b00, S_HI = 2'b01, S_LO = 2'b10, S_CONV = 2'b11} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic deb_q, deb_d, deb_d1_q;
  logic sign_q, sign_d;
  logic [7:0] mag_q, mag_d;
  logic [7:0] value_q, value_d;
  logic valid_q, valid_d, error_q, error_d;
  logic synced, press, in_range, conv;
  logic [7:0] result;
  assign synced = sync_q[SYNC_STAGES-1];
  assign press = deb_q & ~deb_d1_q;
  // negative range reaches one step further than positive (-128 is legal)
  assign in_range = sign_q ? (mag_q <= 8'd128) : ~mag_q[7];
  assign result = sign_q ? (~mag_q + 8'd1) : mag_q;
  assign conv = (state_q == S_CONV);
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], Enter};
    cnt_d = (synced == deb_q || cnt_q == CW'(DEBOUNCE - 1)) ? '0 : cnt_q + CW'(1);
    deb_d = (synced != deb_q && cnt_q == CW'(DEBOUNCE - 1)) ? synced : deb_q;
    sign_d = (state_q == S_SIGN && press) ? Neg : sign_q;
    mag_d = mag_q;
    if (state_q == S_HI && press) mag_d[7:4] = Digit;
    if (state_q == S_LO && press) mag_d[3:0] = Digit;
    state_d = conv ? S_SIGN : (press ? state_t'(state_q + 2'd1) : state_q);
    value_d = (conv && in_range) ? result : value_q;
    valid_d = conv && in_range;
    error_d = conv ? ~in_range : error_q;
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_SIGN;
      sync_q   <= '0;
      cnt_q    <= '0;
      deb_q    <= 1'b0;
      deb_d1_q <= 1'b0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      deb_q    <= deb_d;
      deb_d1_q <= deb_q;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end
  assign Value = value_q;
  assign Valid = valid_q;
  assign Error = error_q;
  assign Stage = state_q;
endmodule

// File: tb/tb_signed_value_entry.sv
// tb_signed_value_entry: table-driven, scoreboarded bench for signed_value_entry
module tb_signed_value_entry;
  logic Clock = 1'b0, Reset = 1'b1, Neg = 1'b0, Enter = 1'b0;
  logic [3:0] Digit = 4'h0;
  logic [7:0] Value;
  logic Valid, Error;
  logic [1:0] Stage;
  int total = 0, passed = 0;
  signed_value_entry #(.SYNC_STAGES(2), .DEBOUNCE(4)) dut (
    .Clock(Clock), .Reset(Reset), .Digit(Digit), .Neg(Neg), .Enter(Enter),
    .Value(Value), .Valid(Valid), .Error(Error), .Stage(Stage)
  );
  always #5 Clock = ~Clock;
  typedef struct {
    logic neg; logic [3:0] hi; logic [3:0] lo; logic tog;
    logic valid; logic [7:0] value; logic err;
  } vec_t;
  typedef struct packed { logic v; logic [7:0] val; logic e; } exp_t;
  exp_t sb[$];
  vec_t vecs[11];
  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction
  task automatic press(input logic n, input logic [3:0] d, input logic [1:0] exp_st, input logic tog);
    logic [1:0] pre_st;
    @(negedge Clock);
    pre_st = Stage;
    Enter = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      Neg = (e == 7 || !tog) ? n : ~n;
      Digit = (e == 7 || !tog) ? d : ~d;
      @(posedge Clock);
      @(negedge Clock);
      if (e == 6) chk("stage_hold", {6'd0, Stage}, {6'd0, pre_st});
      if (e == 7) chk("stage_adv", {6'd0, Stage}, {6'd0, exp_st});
    end
    Enter = 1'b0;
    for (int e = 0; e < 12; e++) begin
      if (tog) begin Neg = ~Neg; Digit = ~Digit; end
      @(negedge Clock);
    end
  endtask
  task automatic entry(input vec_t v);
    sb.push_back({v.valid, v.value, v.err});
    press(v.neg, 4'h0, 2'd1, v.tog);
    press(v.neg, v.hi, 2'd2, v.tog);
    press(v.neg, v.lo, 2'd3, v.tog);
  endtask
  logic [1:0] prev_st = 2'd0;
  always @(negedge Clock) begin
    exp_t x;
    if (Reset) prev_st = 2'd0;
    else begin
      if (prev_st == 2'd3 && Stage == 2'd0) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL sb_empty: conversion with no expected entry at %0t", $time);
        end else begin
          x = sb.pop_front();
          chk("conv_valid", {7'd0, Valid}, {7'd0, x.v});
          chk("conv_value", Value, x.val);
          chk("conv_error", {7'd0, Error}, {7'd0, x.e});
        end
      end else chk("valid_idle", {7'd0, Valid}, 8'd0);
      prev_st = Stage;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    int adv;
    vecs[0]  = '{1'b0, 4'h6, 4'h4, 1'b0, 1'b1, 8'h64, 1'b0};
    vecs[1]  = '{1'b1, 4'h8, 4'h0, 1'b0, 1'b1, 8'h80, 1'b0};
    vecs[2]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 4'h6, 4'h4, 1'b0, 1'b1, 8'h9C, 1'b0};
    vecs[4]  = '{1'b0, 4'h8, 4'h0, 1'b0, 1'b0, 8'h9C, 1'b1};
    vecs[5]  = '{1'b0, 4'h0, 4'h5, 1'b0, 1'b1, 8'h05, 1'b0};
    vecs[6]  = '{1'b0, 4'h7, 4'hF, 1'b0, 1'b1, 8'h7F, 1'b0};
    vecs[7]  = '{1'b1, 4'h8, 4'h1, 1'b0, 1'b0, 8'h7F, 1'b1};
    vecs[8]  = '{1'b1, 4'h0, 4'h1, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[9]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 8'hFF, 1'b1};
    vecs[10] = '{1'b1, 4'h3, 4'hC, 1'b1, 1'b1, 8'hC4, 1'b0};
    repeat (2) @(negedge Clock);
    chk("rst_value", Value, 8'h00);
    chk("rst_valid", {7'd0, Valid}, 8'd0);
    chk("rst_error", {7'd0, Error}, 8'd0);
    chk("rst_stage", {6'd0, Stage}, 8'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    for (int i = 0; i < 11; i++) entry(vecs[i]);
    repeat (4) @(negedge Clock);
    Enter = 1'b1;
    repeat (2) @(negedge Clock);
    Enter = 1'b0;
    repeat (15) @(negedge Clock);
    chk("glitch_stage", {6'd0, Stage}, 8'd0);
    Neg = 1'b0;
    sb.push_back({1'b1, 8'h12, 1'b0});
    Enter = 1'b1;
    adv = 0;
    for (int e = 1; e <= 50; e++) begin
      @(posedge Clock);
      @(negedge Clock);
      if (adv == 0 && Stage != 2'd0) adv = e;
    end
    chk("hold_edge", adv[7:0], 8'd7);
    chk("hold_once", {6'd0, Stage}, 8'd1);
    Enter = 1'b0;
    repeat (12) @(negedge Clock);
    press(1'b0, 4'h1, 2'd2, 1'b0);
    press(1'b0, 4'h2, 2'd3, 1'b0);
    entry(vecs[0]);
    press(1'b1, 4'h0, 2'd1, 1'b0);
    press(1'b1, 4'h6, 2'd2, 1'b0);
    chk("pre_rst_value", Value, 8'h64);
    chk("pre_rst_stage", {6'd0, Stage}, 8'd2);
    #2 Reset = 1'b1;
    #1;
    chk("arst_stage", {6'd0, Stage}, 8'd0);
    chk("arst_value", Value, 8'h00);
    chk("arst_error", {7'd0, Error}, 8'd0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    entry('{1'b1, 4'h0, 4'h5, 1'b0, 1'b1, 8'hFB, 1'b0});
    repeat (4) @(negedge Clock);
    chk("sb_drain", sb.size() > 255 ? 8'hFF : sb.size() > 0 ? 8'h01 : 8'h00, 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
